// File: rtl/gin_pkg.sv
// Shared types and constants for the buffered global input network.
// The entry type is sized at the network's default widths.
package gin_pkg;

  localparam int GIN_DATA_W = 32;
  localparam int GIN_XID_W  = 5;
  localparam int CNT_W      = 16;

  typedef struct packed {
    logic [GIN_DATA_W-1:0] data;
    logic [GIN_XID_W-1:0]  tag_x;
  } gin_entry_t;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/gin_row_stage.sv
// One PE row: entry FIFO, per-column completion mask, X-tag match and head pop.
// Columns that already handshook are masked so partial acceptance never repeats a word.
module gin_row_stage #(
  parameter int COLS       = 8,
  parameter int DATA_W     = 32,
  parameter int XID_W      = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic [XID_W-1:0]       push_tag,
  input  logic [COLS*XID_W-1:0]  xid,
  input  logic [COLS-1:0]        pe_ready,
  output logic [COLS-1:0]        pe_valid,
  output logic [DATA_W-1:0]      pe_data,
  output logic                   full,
  output logic                   nonempty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int E_W   = DATA_W + XID_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [E_W-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [COLS-1:0]  done_r;

  logic [E_W-1:0]   head_s;
  logic [COLS-1:0]  match_s;
  logic [COLS-1:0]  hs_s;
  logic             empty_s;
  logic             pop_s;

  // Head decode: which columns want the head word and whether it can retire.
  always_comb begin
    head_s  = mem_r[rd_ptr_r];
    empty_s = (count_r == {(PTR_W+1){1'b0}});
    match_s = {COLS{1'b0}};
    for (int c = 0; c < COLS; c++) begin
      match_s[c] = (xid[c*XID_W +: XID_W] == head_s[XID_W-1:0]);
    end
    pe_valid = ~{COLS{empty_s}} & match_s & ~done_r;
    hs_s     = pe_valid & pe_ready;
    // A head matching no column satisfies this immediately and retires silently.
    pop_s    = ~empty_s & (&(~match_s | done_r | hs_s));
    pe_data  = head_s[E_W-1:XID_W];
    full     = (count_r == FULL_CNT);
    nonempty = ~empty_s;
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {E_W{1'b0}};
      end
    end else if (push) begin
      mem_r[wr_ptr_r] <= {push_data, push_tag};
    end
  end

  // Pointers, occupancy and completion mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      done_r   <= {COLS{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        done_r   <= {COLS{1'b0}};
      end else begin
        done_r   <= done_r | hs_s;
      end
      case ({push, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/gin_buffered.sv
// Buffered GIN top: Y-tag multicast into per-row FIFOs, ID scan chains, drop counter.
// Y acceptance is all-or-nothing, gated only by registered row-full flags.
module gin_buffered
  import gin_pkg::*;
#(
  parameter int ROWS       = 6,
  parameter int COLS       = 8,
  parameter int DATA_W     = 32,
  parameter int XID_W      = 5,
  parameter int YID_W      = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   GIN_valid,
  output logic                   GIN_ready,
  input  logic [DATA_W-1:0]      GIN_data,
  input  logic [XID_W-1:0]       tag_X,
  input  logic [YID_W-1:0]       tag_Y,
  input  logic                   set_XID,
  input  logic [XID_W-1:0]       XID_scan_in,
  input  logic                   set_YID,
  input  logic [YID_W-1:0]       YID_scan_in,
  input  logic [ROWS*COLS-1:0]   PE_ready,
  output logic [ROWS*COLS-1:0]   PE_valid,
  output logic [ROWS*DATA_W-1:0] PE_data,
  output logic                   busy,
  output logic                   cfg_err,
  output logic [CNT_W-1:0]       drop_cnt
);

  logic [YID_W-1:0] yid_r [ROWS];
  logic [XID_W-1:0] xid_r [ROWS*COLS];
  logic             cfg_err_r;
  logic [CNT_W-1:0] drop_cnt_r;

  logic [ROWS-1:0]  hit_s;
  logic [ROWS-1:0]  full_s;
  logic [ROWS-1:0]  nonempty_s;
  logic             fire_s;

  // Y-stage hit vector and acceptance.
  always_comb begin
    hit_s = {ROWS{1'b0}};
    for (int r = 0; r < ROWS; r++) begin
      hit_s[r] = (yid_r[r] == tag_Y);
    end
    GIN_ready = &(~hit_s | ~full_s);
    fire_s    = GIN_valid & GIN_ready;
    busy      = |nonempty_s;
    cfg_err   = cfg_err_r;
    drop_cnt  = drop_cnt_r;
  end

  // ID scan chains; a shift is refused while any row still holds words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++) begin
        yid_r[i] <= {YID_W{1'b0}};
      end
      for (int i = 0; i < ROWS*COLS; i++) begin
        xid_r[i] <= {XID_W{1'b0}};
      end
    end else begin
      if (set_YID && !busy) begin
        yid_r[0] <= YID_scan_in;
        for (int i = 1; i < ROWS; i++) begin
          yid_r[i] <= yid_r[i-1];
        end
      end
      if (set_XID && !busy) begin
        xid_r[0] <= XID_scan_in;
        for (int i = 1; i < ROWS*COLS; i++) begin
          xid_r[i] <= xid_r[i-1];
        end
      end
    end
  end

  // Sticky config error and saturating drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_err_r  <= 1'b0;
      drop_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if ((set_XID || set_YID) && busy) begin
        cfg_err_r <= 1'b1;
      end
      if (fire_s && !(|hit_s)) begin
        drop_cnt_r <= sat_inc(drop_cnt_r);
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [COLS*XID_W-1:0] xid_slice_s;

    // Flatten this row's XIDs for the row stage.
    always_comb begin
      xid_slice_s = {(COLS*XID_W){1'b0}};
      for (int c = 0; c < COLS; c++) begin
        xid_slice_s[c*XID_W +: XID_W] = xid_r[r*COLS+c];
      end
    end

    gin_row_stage #(
      .COLS       (COLS),
      .DATA_W     (DATA_W),
      .XID_W      (XID_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_row (
      .clk       (clk),
      .rst_n     (rst),
      .push      (fire_s & hit_s[r]),
      .push_data (GIN_data),
      .push_tag  (tag_X),
      .xid       (xid_slice_s),
      .pe_ready  (PE_ready[r*COLS +: COLS]),
      .pe_valid  (PE_valid[r*COLS +: COLS]),
      .pe_data   (PE_data[r*DATA_W +: DATA_W]),
      .full      (full_s[r]),
      .nonempty  (nonempty_s[r])
    );
  end

endmodule
